gradient_window_ctrl: RTL and testbench

//  Raster-scan sequencer for the 5x5 gradient datapath (equ1_2 / mean_calc / equ_7 / equ_4_5 / equ_15 chain).

---
 rtl/gradients_pkg.sv | 21 ++
 rtl/valid_delay_line.sv | 26 ++
 rtl/gradient_window_ctrl.sv | 123 ++++++++++++
 tb/tb_gradient_window_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gradients_pkg.sv
// Shared definitions for the gradient window sequencer: FSM encoding, window radius
// and an elaboration-time log2 helper.
package gradients_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WIN_R = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth, reset-clearable shift register carrying {valid, row, col} alongside the
// gradient datapath; it advances every cycle with no stall input.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/gradient_window_ctrl.sv
// Raster-scan sequencer for the 5x5 gradient datapath: pixel acceptance, window-valid
// strobes with centre coordinates, latency-matched result tags and end-of-frame pulse.
module gradient_window_ctrl
    import gradients_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 6,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          win_shift,
    output logic          win_valid,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          res_valid,
    output logic [CW-1:0] res_row,
    output logic [CW-1:0] res_col,
    output logic          busy,
    output logic          frame_done
);

    localparam int FCW = clog2(PIPE_LAT + 1) + 1;
    localparam logic [CW-1:0]  LAST_COL  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]  LAST_ROW  = CW'(IMG_H - 1);
    localparam logic [CW-1:0]  WIN_EDGE  = CW'(2 * WIN_R);
    localparam logic [CW-1:0]  WIN_OFF   = CW'(WIN_R);
    localparam logic [FCW-1:0] FLUSH_END = FCW'(PIPE_LAT);

    state_t         state;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [FCW-1:0] flush_cnt;
    logic           accept;
    logic           last_pix;
    logic           full_win;

    assign accept    = pix_valid & pix_ready;
    assign win_shift = accept;
    assign last_pix  = accept && (row == LAST_ROW) && (col == LAST_COL);
    // Centre is WIN_R behind the newest pixel, so a window exists once both coords reach 2*WIN_R.
    assign full_win  = (row >= WIN_EDGE) && (col >= WIN_EDGE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            flush_cnt  <= '0;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (accept) begin
                if (full_win) begin
                    win_valid <= 1'b1;
                    win_row   <= row - WIN_OFF;
                    win_col   <= col - WIN_OFF;
                end
                if (col == LAST_COL) begin
                    col <= '0;
                    if (row != LAST_ROW) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        row       <= '0;
                        col       <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last_pix) begin
                        state     <= FLUSH;
                        pix_ready <= 1'b0;
                        flush_cnt <= '0;
                    end
                end
                // Dwell long enough for the final window to clear the delay line.
                FLUSH: begin
                    if (flush_cnt == FLUSH_END) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (1 + 2 * CW)
    ) u_tag_dly (
        .clk (clk),
        .rst (rst),
        .d   ({win_valid, win_row, win_col}),
        .q   ({res_valid, res_row, res_col})
    );

endmodule

// File: tb/tb_gradient_window_ctrl.sv
// Self-checking bench for gradient_window_ctrl: scenario table plus a cycle-scheduled
// reference model of window/result/done timing derived from the pixel raster order.
module tb_gradient_window_ctrl;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 6;
    localparam int PIPE_LAT = 3;
    localparam int CW       = 4;
    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_POST   = 2;

    typedef struct {
        int mode;
        int nframes;
        int abort_after;
        int exp_win;
        int exp_res;
        int exp_done;
        int fr, fc, lr, lc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, pix_valid;
    logic          pix_ready, win_shift, win_valid, res_valid, busy, frame_done;
    logic [CW-1:0] win_row, win_col, res_row, res_col;

    always #5 clk = ~clk;

    gradient_window_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .win_shift(win_shift), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col), .res_valid(res_valid),
        .res_row(res_row), .res_col(res_col), .busy(busy), .frame_done(frame_done)
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit mon_en = 0;
    int m_phase = P_IDLE, m_n = 0, m_done_cyc = -1, m_idle_cyc = -1, m_frames = 0;
    int last_wr = 0, last_wc = 0;
    int exp_wr[int], exp_wc[int], exp_rr[int], exp_rc[int];
    int st_win, st_res, st_done, st_fr, st_fc, st_lr, st_lc;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    // Reference model: raster index -> (r,c); a full window centred at (r-2,c-2) is due
    // one cycle after the accept and its result PIPE_LAT cycles later.
    always @(posedge clk) begin
        int r, c;
        if (!rst) begin
            m_phase = P_IDLE; m_n = 0; m_done_cyc = -1; m_idle_cyc = -1;
            exp_wr.delete(); exp_wc.delete(); exp_rr.delete(); exp_rc.delete();
            last_wr = 0; last_wc = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_STREAM; m_n = 0; end
                P_STREAM: if (pix_valid) begin
                    r = m_n / IMG_W;
                    c = m_n % IMG_W;
                    if (r >= 4 && c >= 4) begin
                        exp_wr[cyc+1] = r - 2; exp_wc[cyc+1] = c - 2;
                        exp_rr[cyc+1+PIPE_LAT] = r - 2; exp_rc[cyc+1+PIPE_LAT] = c - 2;
                    end
                    m_n++;
                    if (m_n == IMG_W * IMG_H) begin
                        m_phase    = P_POST;
                        m_done_cyc = cyc + PIPE_LAT + 2;
                        m_idle_cyc = cyc + PIPE_LAT + 3;
                    end
                end
                default: if (cyc + 1 == m_idle_cyc) begin m_phase = P_IDLE; m_frames++; end
            endcase
        end
        cyc++;
        mon_en = 1;
    end

    always @(negedge clk) begin
        bit ew, er;
        if (mon_en) begin
            ew = exp_wr.exists(cyc);
            er = exp_rr.exists(cyc);
            if (ew) begin last_wr = exp_wr[cyc]; last_wc = exp_wc[cyc]; end
            chk("pix_ready", pix_ready, m_phase == P_STREAM);
            chk("busy", busy, m_phase != P_IDLE);
            chk("win_shift", win_shift, pix_valid && m_phase == P_STREAM);
            chk("win_valid", win_valid, ew);
            chk("win_row", int'(win_row), last_wr);
            chk("win_col", int'(win_col), last_wc);
            chk("res_valid", res_valid, er);
            if (er) begin
                chk("res_row", int'(res_row), exp_rr[cyc]);
                chk("res_col", int'(res_col), exp_rc[cyc]);
            end
            chk("frame_done", frame_done, cyc == m_done_cyc);
            if (win_valid) begin
                st_win++;
                if (st_win == 1) begin st_fr = int'(win_row); st_fc = int'(win_col); end
                st_lr = int'(win_row); st_lc = int'(win_col);
            end
            if (res_valid) st_res++;
            if (frame_done) st_done++;
        end
    end

    task automatic run_case(input int idx, input vec_t v);
        int  budget;
        bit  aborted;
        st_win = 0; st_res = 0; st_done = 0;
        st_fr = -1; st_fc = -1; st_lr = -1; st_lc = -1;
        m_frames = 0; aborted = 0; budget = 0;
        while (!(m_phase == P_IDLE && m_frames == v.nframes)) begin
            if (budget++ > 1500) begin
                chk($sformatf("case%0d_timeout", idx), budget, 0);
                break;
            end
            rst = 1'b1;
            case (v.mode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = (cyc % 2 == 0);
                2:       pix_valid = ($urandom_range(0, 2) != 0);
                default: pix_valid = (cyc % 3 != 0);
            endcase
            if (m_phase == P_IDLE) start = 1'b1;
            else start = ($urandom_range(0, 7) == 0) || (cyc == m_done_cyc);
            if (v.abort_after > 0 && !aborted && m_phase == P_STREAM && m_n == v.abort_after) begin
                rst = 1'b0;
                aborted = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; pix_valid = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("case%0d_win_count", idx), st_win, v.exp_win);
        chk($sformatf("case%0d_res_count", idx), st_res, v.exp_res);
        chk($sformatf("case%0d_done_count", idx), st_done, v.exp_done);
        chk($sformatf("case%0d_first_row", idx), st_fr, v.fr);
        chk($sformatf("case%0d_first_col", idx), st_fc, v.fc);
        chk($sformatf("case%0d_last_row", idx), st_lr, v.lr);
        chk($sformatf("case%0d_last_col", idx), st_lc, v.lc);
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{0, 1, 0,  8,  8, 1, 2, 2, 3, 5};   // back-to-back pixels
        tbl[1] = '{1, 1, 0,  8,  8, 1, 2, 2, 3, 5};   // alternating gaps
        tbl[2] = '{2, 1, 0,  8,  8, 1, 2, 2, 3, 5};   // random gaps
        tbl[3] = '{0, 1, 20, 8,  8, 1, 2, 2, 3, 5};   // reset after 20 accepts, then full frame
        tbl[4] = '{0, 2, 0,  16, 16, 2, 2, 2, 3, 5};  // two frames back-to-back
        tbl[5] = '{3, 2, 0,  16, 16, 2, 2, 2, 3, 5};  // periodic gaps, two frames

        rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_win_row", int'(win_row), 0);
        chk("rst_res_col", int'(res_col), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        pix_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_pix_ready", pix_ready, 0);
            chk("idle_win_shift", win_shift, 0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_case(i, tbl[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
